count_seq_monitor: RTL
======================

// Module: count_seq_monitor
// PURPOSE
//  Receive-side checker for the up/down counter bus. Samples a WIDTH-bit count
//  stream each enabled cycle and infers step direction (hold/up/down/jump).
//  Locks onto a legal sequence, flags and counts illegal jumps, counts wraps.
//  Sits between a counter instance and status/debug logic; observes only.
// PARAMETERS
//  WIDTH      3  count bus width; must be >= 2
//  ERR_LIMIT  3  consecutive illegal steps in LOCKED before dropping to UNSYNC
//  STAT_W     8  width of err_count and wrap_count
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       reset, asynchronous, active-low
//  clear        in   1       sync clear: state->UNSYNC, stats->0; beats sample_en
//  sample_en    in   1       count_in valid this cycle
//  count_in     in   WIDTH   observed counter value
//  exp_up_down  in   1       expected direction (1 = up, 0 = down)
//  dir_out      out  2       last step: 00 hold, 01 up, 10 down, 11 jump
//  locked       out  1       1 while state == LOCKED
//  err_pulse    out  1       1-cycle strobe per counted error
//  err_count    out  STAT_W  counted errors, saturates at all-ones
//  wrap_count   out  STAT_W  wrap events, modulo 2**STAT_W
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous and active-low (rst).
//  - rst low: immediately state=UNSYNC, last=0, consec=0, all outputs 0.
//  - All outputs registered; a sample at edge N shows its result after edge N.
//  - dir_out/wrap_count update only on samples; err_pulse low when not sampling.
//  - Step class vs stored last (mod 2**WIDTH): equal=hold, last+1=up,
//    last-1=down, anything else=jump.
//  - Wrap: up from 2**WIDTH-1 to 0, or down from 0 to 2**WIDTH-1 -> wrap_count+1,
//    counted in SYNC and LOCKED.
//  - FSM:
//    UNSYNC: sample -> last=count_in, dir_out=00, go SYNC. No error.
//    SYNC:   hold -> stay; up/down -> LOCKED; jump -> last=count_in, stay,
//            no error counted. dir_out reports class.
//    LOCKED: legal step -> consec=0. Error step -> err_pulse=1, err_count+1
//            (sat), consec+1; if consec reaches ERR_LIMIT -> UNSYNC, consec=0.
//  - last=count_in on every sample in SYNC/LOCKED.
//  - clear with sample_en same cycle: clear wins, sample dropped.
//  - rst mid-stream: async abort; first sample after release is UNSYNC capture.
// CONFIGURATION
//  MON_DIR_CHECK_EN defined: in LOCKED, up step with exp_up_down=0 or down step
//    with exp_up_down=1 is an error step (same handling as jump); hold never is.
//  Not defined: only jumps are error steps; exp_up_down ignored (port kept).
// TESTING
//  1. Reset, sample 0..7,0 (up) -> locked=1 after 2nd sample, dir_out=01,
//     wrap_count=1 after 7->0, err_count=0, err_pulse never high.
//  2. LOCKED at 2, sample 5 -> dir_out=11, err_pulse high 1 cycle, err_count=1,
//     locked stays 1; next sample 6 -> no error, consec reset.
//  3. LOCKED, 3 consecutive jumps (ERR_LIMIT=3) -> err_count+3, locked=0 after
//     3rd; next sample captured as UNSYNC.
//  4. Sample 1,0,7 exp_up_down=0 -> dir_out=10, wrap_count+1, no error; with
//     MON_DIR_CHECK_EN and exp_up_down=1 -> err_pulse on each step in LOCKED.
//  5. Sample 4,4,4 while locked -> dir_out=00, no error; sample_en=0 gaps keep
//     dir_out/counters unchanged.
//  6. rst low between edges mid-stream -> all outputs 0 at once; clear with
//     sample_en same cycle -> UNSYNC, stats 0, sample ignored.

Source files
------------

// File: rtl/count_seq_monitor.sv
// count_seq_monitor
//   Receive-side checker for an up/down counter bus. On each enabled sample it
//   classifies the step against the previous value (hold/up/down/jump), locks
//   onto a legal sequence, flags and counts illegal steps, and counts wraps.
//   Observes only; it never drives the counter.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-low
//   clear        in   synchronous clear of state and statistics (beats sample_en)
//   sample_en    in   count_in valid this cycle
//   count_in     in   observed counter value [WIDTH]
//   exp_up_down  in   expected direction (1 = up, 0 = down)
//   dir_out      out  last step class: 00 hold, 01 up, 10 down, 11 jump
//   locked       out  high while the monitor is in LOCKED
//   err_pulse    out  one-cycle strobe per counted error
//   err_count    out  counted errors, saturating [STAT_W]
//   wrap_count   out  wrap events, modulo 2**STAT_W [STAT_W]
//
// Configuration
//   MON_DIR_CHECK_EN  when defined, a step against exp_up_down in LOCKED is an
//                     error step; otherwise only jumps are, and exp_up_down is
//                     ignored.

module count_seq_monitor #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned ERR_LIMIT = 3,
  parameter int unsigned STAT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sample_en,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              exp_up_down,
  output logic [1:0]        dir_out,
  output logic              locked,
  output logic              err_pulse,
  output logic [STAT_W-1:0] err_count,
  output logic [STAT_W-1:0] wrap_count
);

  localparam int unsigned CONSEC_W = (ERR_LIMIT < 2) ? 1 : $clog2(ERR_LIMIT + 1);

  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [1:0] DIR_JUMP = 2'b11;

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_last;
  logic [CONSEC_W-1:0] r_consec;
  logic [1:0]          r_dir;
  logic                r_locked;
  logic                r_err_pulse;
  logic [STAT_W-1:0]   r_err_cnt;
  logic [STAT_W-1:0]   r_wrap_cnt;

  state_t              w_state_nxt;
  logic [WIDTH-1:0]    w_last_nxt;
  logic [CONSEC_W-1:0] w_consec_nxt;
  logic [1:0]          w_dir_nxt;
  logic                w_err_pulse_nxt;
  logic [STAT_W-1:0]   w_err_cnt_nxt;
  logic [STAT_W-1:0]   w_wrap_cnt_nxt;

  logic [WIDTH-1:0]    w_last_inc;
  logic [WIDTH-1:0]    w_last_dec;
  logic [1:0]          w_class;
  logic                w_wrap;
  logic                w_err_step;

  // Step classification relative to the stored previous sample (modular).
  assign w_last_inc = WIDTH'(r_last + WIDTH'(1));
  assign w_last_dec = WIDTH'(r_last - WIDTH'(1));

  always_comb begin
    w_class = DIR_JUMP;
    if (count_in == r_last) begin
      w_class = DIR_HOLD;
    end else if (count_in == w_last_inc) begin
      w_class = DIR_UP;
    end else if (count_in == w_last_dec) begin
      w_class = DIR_DOWN;
    end
  end

  // Wrap: up out of all-ones or down out of zero.
  assign w_wrap = ((w_class == DIR_UP)   && (r_last == {WIDTH{1'b1}})) ||
                  ((w_class == DIR_DOWN) && (r_last == {WIDTH{1'b0}}));

`ifdef MON_DIR_CHECK_EN
  assign w_err_step = (w_class == DIR_JUMP) ||
                      ((w_class == DIR_UP)   && !exp_up_down) ||
                      ((w_class == DIR_DOWN) &&  exp_up_down);
`else
  logic w_unused_exp_up_down;
  assign w_unused_exp_up_down = exp_up_down;
  assign w_err_step = (w_class == DIR_JUMP);
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_consec_nxt    = r_consec;
    w_dir_nxt       = r_dir;
    w_err_pulse_nxt = 1'b0;
    w_err_cnt_nxt   = r_err_cnt;
    w_wrap_cnt_nxt  = r_wrap_cnt;

    if (clear) begin
      w_state_nxt    = ST_UNSYNC;
      w_consec_nxt   = '0;
      w_err_cnt_nxt  = '0;
      w_wrap_cnt_nxt = '0;
    end else if (sample_en) begin
      unique case (r_state)
        ST_UNSYNC: begin
          w_last_nxt  = count_in;
          w_dir_nxt   = DIR_HOLD;
          w_state_nxt = ST_SYNC;
        end
        ST_SYNC: begin
          w_last_nxt = count_in;
          w_dir_nxt  = w_class;
          if (w_wrap) begin
            w_wrap_cnt_nxt = STAT_W'(r_wrap_cnt + STAT_W'(1));
          end
          // Jumps re-seed the reference without error; a real step locks.
          if ((w_class == DIR_UP) || (w_class == DIR_DOWN)) begin
            w_state_nxt = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          w_last_nxt = count_in;
          w_dir_nxt  = w_class;
          if (w_wrap) begin
            w_wrap_cnt_nxt = STAT_W'(r_wrap_cnt + STAT_W'(1));
          end
          if (w_err_step) begin
            w_err_pulse_nxt = 1'b1;
            if (r_err_cnt != {STAT_W{1'b1}}) begin
              w_err_cnt_nxt = STAT_W'(r_err_cnt + STAT_W'(1));
            end
            // Too many consecutive errors: give up the lock.
            if (r_consec == CONSEC_W'(ERR_LIMIT - 1)) begin
              w_consec_nxt = '0;
              w_state_nxt  = ST_UNSYNC;
            end else begin
              w_consec_nxt = CONSEC_W'(r_consec + CONSEC_W'(1));
            end
          end else begin
            w_consec_nxt = '0;
          end
        end
        default: begin
          w_state_nxt  = ST_UNSYNC;
          w_consec_nxt = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_UNSYNC;
      r_last      <= '0;
      r_consec    <= '0;
      r_dir       <= DIR_HOLD;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
      r_wrap_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_consec    <= w_consec_nxt;
      r_dir       <= w_dir_nxt;
      r_locked    <= (w_state_nxt == ST_LOCKED);
      r_err_pulse <= w_err_pulse_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_wrap_cnt  <= w_wrap_cnt_nxt;
    end
  end

  assign dir_out    = r_dir;
  assign locked     = r_locked;
  assign err_pulse  = r_err_pulse;
  assign err_count  = r_err_cnt;
  assign wrap_count = r_wrap_cnt;

endmodule
